// File: rtl/cp0_intctrl_if.sv
// Signal bundle between the CP0 interrupt controller and the core/interrupt sources.
// master drives interrupt sources, Status and pipeline readiness; slave is the controller.
interface cp0_intctrl_if;
    logic [5:0]  hw_int;
    logic        sw_int_we;
    logic [1:0]  sw_int_wdata;
    logic [31:0] status;
    logic        pipe_ready;
    logic        int_take;
    logic [4:0]  exccode;
    logic [7:0]  cause_ip;
    logic        int_pending;
    logic [2:0]  int_num;

    modport master (
        output hw_int, sw_int_we, sw_int_wdata, status, pipe_ready,
        input  int_take, exccode, cause_ip, int_pending, int_num
    );

    modport slave (
        input  hw_int, sw_int_we, sw_int_wdata, status, pipe_ready,
        output int_take, exccode, cause_ip, int_pending, int_num
    );
endinterface

// File: rtl/cp0_intctrl.sv
// CP0 interrupt controller: Cause IP capture, masking, priority select and take sequencing.
// Define CP0_INT_SYNC_EN for a two-flop hw_int synchronizer; otherwise a single capture stage.
//
// state    | meaning
// IDLE     | no enabled, unmasked interrupt pending
// ARMED    | interrupt pending, waiting for an instruction boundary
// TAKEN    | int_take pulse cycle, int_num latched
// WAIT_EXL | take issued, waiting for the exception path to raise EXL
module cp0_intctrl (
    input logic          clk,
    input logic          reset,
    cp0_intctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ARMED, TAKEN, WAIT_EXL} state_t;

    state_t     state;
    logic [5:0] hw_sync;
    logic [1:0] sw_ip;
    logic [7:0] cause_ip;
    logic [7:0] masked;
    logic       int_pending;
    logic [2:0] prio;
    logic       int_take;
    logic [2:0] int_num;
    logic       unused_status;

`ifdef CP0_INT_SYNC_EN
    logic [5:0] hw_meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hw_meta <= 6'd0;
            hw_sync <= 6'd0;
        end else begin
            hw_meta <= bus.hw_int;
            hw_sync <= hw_meta;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hw_sync <= 6'd0;
        else       hw_sync <= bus.hw_int;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              sw_ip <= 2'd0;
        else if (bus.sw_int_we) sw_ip <= bus.sw_int_wdata;
    end

    assign cause_ip      = {hw_sync, sw_ip};
    assign masked        = cause_ip & bus.status[15:8];
    assign int_pending   = (|masked) & bus.status[0] & ~bus.status[1];
    assign unused_status = ^{bus.status[31:16], bus.status[7:2]};

    // IP7 wins: later (higher) indices overwrite lower ones
    always_comb begin
        prio = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (masked[i]) prio = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            int_take <= 1'b0;
            int_num  <= 3'd0;
        end else begin
            int_take <= 1'b0;
            case (state)
                IDLE: begin
                    if (int_pending) state <= ARMED;
                end
                ARMED: begin
                    if (!int_pending) begin
                        state <= IDLE;
                    end else if (bus.pipe_ready) begin
                        state    <= TAKEN;
                        int_take <= 1'b1;
                        int_num  <= prio;
                    end
                end
                TAKEN: begin
                    state <= WAIT_EXL;
                end
                WAIT_EXL: begin
                    if (bus.status[1]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cause_ip    = cause_ip;
    assign bus.int_pending = int_pending;
    assign bus.int_take    = int_take;
    assign bus.int_num     = int_num;
    assign bus.exccode     = 5'd0;

endmodule
